// File: rtl/ov7670_pkg.sv
// Shared definitions for the OV7670 SCCB configuration sequencer.
package ov7670_pkg;

  localparam logic [15:0] SCCB_END        = 16'hFFFF;
  localparam logic [7:0]  SCCB_DELAY_ADDR = 8'hF0;
  localparam logic [7:0]  DEV_ID_DEFAULT  = 8'h42;

  // Entries available in the parameter-supplied replacement table.
  localparam int unsigned ROM_OVR_DEPTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    BIT,
    STOP,
    GAP,
    DELAY,
    FINISH
  } sccb_state_t;

  // Ninth bit of each 9-bit phase is the don't-care/ACK slot.
  function automatic logic is_ack_slot(input logic [4:0] b);
    return (b == 5'd8) || (b == 5'd17) || (b == 5'd26);
  endfunction

endpackage

// File: rtl/ov7670_reg_rom.sv
// Combinational OV7670 register table (RGB565, QVGA); entry = {reg_addr, reg_data}.
// A parameter-supplied table may replace the camera set for short test runs.
module ov7670_reg_rom
  import ov7670_pkg::*;
#(
  parameter bit                            USE_OVERRIDE   = 1'b0,
  parameter logic [ROM_OVR_DEPTH*16-1:0]   OVERRIDE_TABLE = '1
) (
  input  logic [7:0]  index,
  output logic [15:0] entry
);

  logic [15:0] cam_entry;

  always_comb begin
    case (index)
      8'd0:    cam_entry = 16'h1280;  // COM7 soft reset
      8'd1:    cam_entry = 16'hF00A;  // wait 10 ms for the reset to settle
      8'd2:    cam_entry = 16'h1214;  // COM7 QVGA + RGB
      8'd3:    cam_entry = 16'h40D0;  // COM15 RGB565, full range
      8'd4:    cam_entry = 16'h8C00;
      8'd5:    cam_entry = 16'h1101;
      8'd6:    cam_entry = 16'h0C04;
      8'd7:    cam_entry = 16'h3E19;
      8'd8:    cam_entry = 16'h7211;
      8'd9:    cam_entry = 16'h73F1;
      8'd10:   cam_entry = 16'hA202;
      8'd11:   cam_entry = 16'h1716;
      8'd12:   cam_entry = 16'h1804;
      8'd13:   cam_entry = 16'h3224;
      8'd14:   cam_entry = 16'h1902;
      8'd15:   cam_entry = 16'h1A7A;
      8'd16:   cam_entry = 16'h030A;
      8'd17:   cam_entry = 16'h1500;
      8'd18:   cam_entry = 16'h3A04;
      8'd19:   cam_entry = 16'h3DC0;
      8'd20:   cam_entry = 16'h4F80;
      8'd21:   cam_entry = 16'h5080;
      8'd22:   cam_entry = 16'h5100;
      8'd23:   cam_entry = 16'h5222;
      8'd24:   cam_entry = 16'h535E;
      8'd25:   cam_entry = 16'h5480;
      8'd26:   cam_entry = 16'h589E;
      8'd27:   cam_entry = 16'h13E7;
      8'd28:   cam_entry = 16'h6B4A;
      default: cam_entry = SCCB_END;
    endcase
  end

  always_comb begin
    entry = cam_entry;
    if (USE_OVERRIDE) begin
      entry = (index[7:3] == '0) ? OVERRIDE_TABLE[{index[2:0], 4'b0000} +: 16] : SCCB_END;
    end
  end

endmodule

// File: rtl/ov7670_sccb_config.sv
// Walks the register ROM and issues one SCCB 3-phase write per entry.
// The board level maps the open-drain pin as SIOD = siod_oe ? 1'b0 : 1'bz.
module ov7670_sccb_config
  import ov7670_pkg::*;
#(
  parameter int unsigned                 CLK_HZ       = 24_000_000,
  parameter int unsigned                 SCCB_HZ      = 100_000,
  parameter logic [7:0]                  DEV_ID       = DEV_ID_DEFAULT,
  parameter int unsigned                 GAP_QUARTERS = 8,
  parameter bit                          ROM_OVERRIDE = 1'b0,
  parameter logic [ROM_OVR_DEPTH*16-1:0] ROM_TABLE    = '1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       sioc,
  output logic       siod_oe,
  output logic       busy,
  output logic       done,
  output logic [7:0] index
);

  localparam int unsigned QDIV     = CLK_HZ / (4 * SCCB_HZ);
  localparam int unsigned MS_CYC   = CLK_HZ / 1000;
  localparam logic [4:0]  LAST_BIT = 5'd26;

  sccb_state_t state, state_n;
  logic [31:0] qcnt, qcnt_n;
  logic [1:0]  q, q_n;
  logic [4:0]  bit_cnt, bit_n;
  logic [26:0] sh, sh_n;
  logic [31:0] gap_cnt, gap_n;
  logic [31:0] dly_cnt, dly_n;
  logic [7:0]  index_n;
  logic        busy_n, done_n, sioc_n, oe_n;
  logic        timed, tick, advance;
  logic [15:0] rom_entry;

  ov7670_reg_rom #(
    .USE_OVERRIDE   (ROM_OVERRIDE),
    .OVERRIDE_TABLE (ROM_TABLE)
  ) u_rom (
    .index (index),
    .entry (rom_entry)
  );

  // Quarter divider restarts on entry to START so every quarter is full length.
  assign timed = (state == START) || (state == BIT) || (state == STOP) || (state == GAP);
  assign tick  = timed && (qcnt == QDIV - 1);

  always_comb begin
    state_n = state;
    qcnt_n  = (timed && !tick) ? qcnt + 32'd1 : '0;
    q_n     = q;
    bit_n   = bit_cnt;
    sh_n    = sh;
    gap_n   = gap_cnt;
    dly_n   = dly_cnt;
    index_n = index;
    busy_n  = busy;
    done_n  = done;
    advance = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_n = LOAD;
          index_n = '0;
          busy_n  = 1'b1;
          done_n  = 1'b0;
        end
      end
      LOAD: begin
        q_n   = '0;
        bit_n = '0;
        gap_n = '0;
        if (rom_entry == SCCB_END) begin
          state_n = FINISH;
        end else if (rom_entry[15:8] == SCCB_DELAY_ADDR) begin
          state_n = DELAY;
          dly_n   = 32'(rom_entry[7:0]) * MS_CYC;
        end else begin
          state_n = START;
          sh_n    = {DEV_ID, 1'b0, rom_entry[15:8], 1'b0, rom_entry[7:0], 1'b0};
        end
      end
      START: begin
        if (tick) state_n = BIT;
      end
      BIT: begin
        if (tick) begin
          q_n = q + 2'd1;
          if (q == 2'd3) begin
            if (bit_cnt == LAST_BIT) begin
              state_n = STOP;
            end else begin
              bit_n = bit_cnt + 5'd1;
              sh_n  = {sh[25:0], 1'b0};
            end
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (q == 2'd2) begin
            state_n = GAP;
            q_n     = '0;
          end else begin
            q_n = q + 2'd1;
          end
        end
      end
      GAP: begin
        if (tick) begin
          if (gap_cnt + 32'd1 >= GAP_QUARTERS) advance = 1'b1;
          else gap_n = gap_cnt + 32'd1;
        end
      end
      DELAY: begin
        if (dly_cnt <= 32'd1) advance = 1'b1;
        else dly_n = dly_cnt - 32'd1;
      end
      FINISH: begin
        state_n = IDLE;
        busy_n  = 1'b0;
        done_n  = 1'b1;
      end
      default: state_n = IDLE;
    endcase

    if (advance) begin
      if (index == 8'hFF) begin
        state_n = FINISH;
      end else begin
        state_n = LOAD;
        index_n = index + 8'd1;
      end
    end

    // Bus pins are a registered function of the next state and quarter.
    sioc_n = 1'b1;
    oe_n   = 1'b0;
    case (state_n)
      START: oe_n = 1'b1;
      BIT: begin
        sioc_n = q_n[1];
        oe_n   = ~sh_n[26] & ~is_ack_slot(bit_n);
      end
      STOP: begin
        sioc_n = (q_n != 2'd0);
        oe_n   = (q_n != 2'd2);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      qcnt    <= '0;
      q       <= '0;
      bit_cnt <= '0;
      sh      <= '0;
      gap_cnt <= '0;
      dly_cnt <= '0;
      index   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sioc    <= 1'b1;
      siod_oe <= 1'b0;
    end else begin
      state   <= state_n;
      qcnt    <= qcnt_n;
      q       <= q_n;
      bit_cnt <= bit_n;
      sh      <= sh_n;
      gap_cnt <= gap_n;
      dly_cnt <= dly_n;
      index   <= index_n;
      busy    <= busy_n;
      done    <= done_n;
      sioc    <= sioc_n;
      siod_oe <= oe_n;
    end
  end

endmodule

// File: tb/tb_ov7670_sccb_config.sv
// Scoreboard bench: stimulus queues expected frames/runs, a monitor decodes the bus and compares.
module tb_ov7670_sccb_config;

  localparam int unsigned GAPQ      = 8;
  localparam int unsigned WRITE_CYC = 1 + 108 + 3 + GAPQ;              // QDIV = 1
  localparam int unsigned RUN1_CYC  = 1 + WRITE_CYC + 1 + 1;           // LOAD, write, LOAD(end), FINISH
  localparam int unsigned DLY_CYC   = 2 * 4000;
  localparam int unsigned RUN2_CYC  = 1 + DLY_CYC + 1 + WRITE_CYC + 1 + 1;
  localparam logic [127:0] TABLE_A  = {{6{16'hFFFF}}, 16'hFFFF, 16'h1280};
  localparam logic [127:0] TABLE_B  = {{5{16'hFFFF}}, 16'hFFFF, 16'h1280, 16'hF002};

  typedef struct {
    int unsigned dut;
    int unsigned idx;
    int unsigned cycles;
    int unsigned t0;
  } run_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_w [2];
  logic        sioc_w  [2];
  logic        oe_w    [2];
  logic        busy_w  [2];
  logic        done_w  [2];
  logic [7:0]  idx_w   [2];

  int unsigned cyc = 0;
  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  logic [23:0] exp_frames [$];
  run_t        exp_runs   [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ov7670_sccb_config #(
    .CLK_HZ(4_000_000), .SCCB_HZ(1_000_000), .DEV_ID(8'h42), .GAP_QUARTERS(GAPQ),
    .ROM_OVERRIDE(1'b1), .ROM_TABLE(TABLE_A)
  ) dut (
    .clk(clk), .reset(rst), .start(start_w[0]), .sioc(sioc_w[0]), .siod_oe(oe_w[0]),
    .busy(busy_w[0]), .done(done_w[0]), .index(idx_w[0])
  );

  ov7670_sccb_config #(
    .CLK_HZ(4_000_000), .SCCB_HZ(1_000_000), .DEV_ID(8'h42), .GAP_QUARTERS(GAPQ),
    .ROM_OVERRIDE(1'b1), .ROM_TABLE(TABLE_B)
  ) dut_dly (
    .clk(clk), .reset(rst), .start(start_w[1]), .sioc(sioc_w[1]), .siod_oe(oe_w[1]),
    .busy(busy_w[1]), .done(done_w[1]), .index(idx_w[1])
  );

  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
  endfunction

  // Monitor: decode START/bits/STOP and done edges from both instances.
  logic        ps    [2] = '{1'b1, 1'b1};
  logic        psd   [2] = '{1'b1, 1'b1};
  logic        pdone [2] = '{1'b0, 1'b0};
  logic        in_fr [2] = '{1'b0, 1'b0};
  int unsigned nbits [2];
  int unsigned tfs   [2];
  logic [31:0] word  [2];
  logic [23:0] fexp;
  run_t        rexp;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic s, sd;
      s  = sioc_w[d];
      sd = ~oe_w[d];
      if (rst) begin
        in_fr[d] = 1'b0;
      end else if (ps[d] && s && psd[d] && !sd) begin
        in_fr[d] = 1'b1;
        nbits[d] = 0;
        word[d]  = '0;
        tfs[d]   = cyc;
      end else if (in_fr[d] && !ps[d] && s) begin
        word[d]  = {word[d][30:0], sd};
        nbits[d] = nbits[d] + 1;
      end else if (in_fr[d] && ps[d] && s && !psd[d] && sd) begin
        in_fr[d] = 1'b0;
        if (exp_frames.size() == 0) begin
          check("frame expected in queue", exp_frames.size(), 1);
        end else begin
          fexp = exp_frames.pop_front();
          check("frame bytes id/addr/data", {word[d][27:20], word[d][18:11], word[d][9:2]}, fexp);
          check("frame sioc rises (27 bits + stop)", nbits[d], 28);
          check("frame start-to-stop cycles", cyc - tfs[d], 111);
        end
      end
      if (!rst && done_w[d] && !pdone[d]) begin
        if (exp_runs.size() == 0) begin
          check("run expected in queue", exp_runs.size(), 1);
        end else begin
          rexp = exp_runs.pop_front();
          check("run instance", d, rexp.dut);
          check("run index at done", idx_w[d], rexp.idx);
          check("run busy at done", busy_w[d], 0);
          check("run cycles start-to-done", cyc - rexp.t0, rexp.cycles);
        end
      end
      ps[d]    = s;
      psd[d]   = sd;
      pdone[d] = done_w[d];
    end
  end

  task automatic start_pulse(input int d, output int unsigned t0);
    @(posedge clk); #1;
    start_w[d] = 1'b1;
    t0 = cyc + 1;
    @(posedge clk); #1;
    start_w[d] = 1'b0;
  endtask

  task automatic expect_run(input int unsigned d, input int unsigned idx,
                            input int unsigned cycles, input int unsigned t0);
    run_t r;
    r.dut = d; r.idx = idx; r.cycles = cycles; r.t0 = t0;
    exp_runs.push_back(r);
  endtask

  task automatic wait_idle(input int d, input int unsigned budget);
    int unsigned n = 0;
    while (!(done_w[d] && !busy_w[d]) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("run finished within budget", done_w[d], 1);
    repeat (4) @(posedge clk);
  endtask

  initial begin
    int unsigned t0;
    int unsigned noisy;
    rst = 1'b1;
    start_w[0] = 1'b0;
    start_w[1] = 1'b0;
    repeat (3) @(posedge clk); #1;
    for (int d = 0; d < 2; d++)
      check("reset {sioc,oe,busy,done,index}",
            {sioc_w[d], oe_w[d], busy_w[d], done_w[d], idx_w[d]}, {4'b1000, 8'h00});
    rst = 1'b0;

    // Single write then end marker.
    exp_frames.push_back(24'h421280);
    start_pulse(0, t0);
    expect_run(0, 1, RUN1_CYC, t0);
    check("busy rises after start", busy_w[0], 1);
    check("done low during run", done_w[0], 0);
    wait_idle(0, 1000);

    // Restart after done, with start pulses during busy that must be ignored.
    exp_frames.push_back(24'h421280);
    start_pulse(0, t0);
    expect_run(0, 1, RUN1_CYC, t0);
    check("done clears on restart", done_w[0], 0);
    check("index restarts at 0", idx_w[0], 0);
    for (int k = 0; k < 2; k++) begin
      repeat (40) @(posedge clk); #1;
      start_w[0] = 1'b1;
      @(posedge clk); #1;
      start_w[0] = 1'b0;
    end
    wait_idle(0, 1000);

    // Delay entry: bus stays idle for 2 ms, then the write follows.
    exp_frames.push_back(24'h421280);
    start_pulse(1, t0);
    expect_run(1, 2, RUN2_CYC, t0);
    noisy = 0;
    repeat (DLY_CYC) begin
      @(posedge clk); #1;
      if (!sioc_w[1] || oe_w[1]) noisy++;
    end
    check("bus activity cycles during delay", noisy, 0);
    check("index during delay", idx_w[1], 0);
    check("busy during delay", busy_w[1], 1);
    wait_idle(1, 1000);

    // Reset in the middle of the bit stream: quarter 0 of bit 7 (DEV_ID lsb = 0).
    start_pulse(0, t0);
    repeat (30) @(posedge clk); #1;
    check("mid-BIT {sioc,oe}", {sioc_w[0], oe_w[0]}, 2'b01);
    rst = 1'b1;
    #1;
    check("reset mid-BIT {sioc,oe,busy,done,index}",
          {sioc_w[0], oe_w[0], busy_w[0], done_w[0], idx_w[0]}, {4'b1000, 8'h00});
    @(posedge clk); #1;
    rst = 1'b0;

    // A fresh run after the truncated frame.
    exp_frames.push_back(24'h421280);
    start_pulse(0, t0);
    expect_run(0, 1, RUN1_CYC, t0);
    wait_idle(0, 1000);

    repeat (5) @(posedge clk);
    check("unconsumed expected frames", exp_frames.size(), 0);
    check("unconsumed expected runs", exp_runs.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
